// File: rtl/kbd_bcd_entry_pkg.sv
// Shared scan codes, key classes and FSM states for the keypad BCD entry block.
// Scan codes are 9 bits wide; bit 8 marks an E0-extended code.
package kbd_pkg;

  // Index i of each table is the scan code for decimal digit i.
  localparam logic [8:0] SC_DIGIT_TOP [10] = '{
    9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046
  };
  localparam logic [8:0] SC_DIGIT_KP [10] = '{
    9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
  };
  localparam logic [8:0] SC_BKSP     = 9'h066;
  localparam logic [8:0] SC_ENTER    = 9'h05A;
  localparam logic [8:0] SC_KP_ENTER = 9'h15A;
  localparam logic [8:0] SC_ESC      = 9'h076;

  typedef enum logic [2:0] {
    KC_NONE,
    KC_DIGIT,
    KC_BKSP,
    KC_ENTER,
    KC_ESC
  } key_class_e;

  typedef enum logic {
    ST_ENTRY,
    ST_DONE
  } state_e;

endpackage

// File: rtl/kbd_bcd_entry_if.sv
// Bundle between the PS/2 decoder side (master) and the entry FSM (slave).
interface kbd_bcd_entry_if #(
  parameter int DIGITS   = 4,
  parameter int OPERANDS = 2
);
  localparam int IDX_W = (OPERANDS > 1) ? $clog2(OPERANDS) : 1;
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                         key_valid;
  logic [8:0]                   last_change;
  logic [511:0]                 key_down;
  logic [OPERANDS*DIGITS*4-1:0] operands;
  logic [IDX_W-1:0]             op_idx;
  logic [CNT_W-1:0]             digit_cnt;
  logic                         entry_done;
  logic                         done_pulse;
  logic                         ovf_pulse;

  modport master (
    output key_valid, last_change, key_down,
    input  operands, op_idx, digit_cnt, entry_done, done_pulse, ovf_pulse
  );

  modport slave (
    input  key_valid, last_change, key_down,
    output operands, op_idx, digit_cnt, entry_done, done_pulse, ovf_pulse
  );
endinterface

// File: rtl/kbd_bcd_entry_class.sv
// Maps a 9-bit scan code onto its key class and, for digit keys, the BCD value.
// Top-row and keypad digits share one class so the FSM never sees which row was used.
module kbd_scancode_class
  import kbd_pkg::*;
(
  input  logic [8:0] i_code,
  output key_class_e o_class,
  output logic [3:0] o_digit
);

  always_comb begin
    o_class = KC_NONE;
    o_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (i_code == SC_DIGIT_TOP[i] || i_code == SC_DIGIT_KP[i]) begin
        o_class = KC_DIGIT;
        o_digit = 4'(i);
      end
    end
    case (i_code)
      SC_BKSP:              o_class = KC_BKSP;
      SC_ENTER, SC_KP_ENTER: o_class = KC_ENTER;
      SC_ESC:               o_class = KC_ESC;
      default: ;
    endcase
  end

endmodule

// File: rtl/kbd_bcd_entry.sv
// Multi-operand decimal keypad entry: shifts BCD digits into the current operand,
// supports backspace, enter/advance and escape, and flags completion and overflow.
module kbd_bcd_entry
  import kbd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int OPERANDS = 2
) (
  input logic           fcrystal,
  input logic           rst,
  kbd_bcd_entry_if.slave bus
);

  localparam int OPW   = DIGITS * 4;
  localparam int TOTW  = OPERANDS * OPW;
  localparam int IDX_W = (OPERANDS > 1) ? $clog2(OPERANDS) : 1;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OPERANDS - 1);

  state_e           r_state, w_stateNext;
  logic [TOTW-1:0]  r_operands, w_opsNext;
  logic [IDX_W-1:0] r_op_idx, w_idxNext;
  logic [CNT_W-1:0] r_cnt, w_cntNext;
  logic             r_done, w_doneNext;
  logic             r_donePulse, w_donePulseNext;
  logic             r_ovfPulse, w_ovfPulseNext;

  logic             w_press;
  key_class_e       w_class;
  logic [3:0]       w_digit;

  // Break events leave the pressed map bit clear, so they never count as presses.
  assign w_press = bus.key_valid & bus.key_down[bus.last_change];

  kbd_scancode_class u_class (
    .i_code  (bus.last_change),
    .o_class (w_class),
    .o_digit (w_digit)
  );

  always_comb begin
    w_stateNext     = r_state;
    w_opsNext       = r_operands;
    w_idxNext       = r_op_idx;
    w_cntNext       = r_cnt;
    w_doneNext      = r_done;
    w_donePulseNext = 1'b0;
    w_ovfPulseNext  = 1'b0;
    if (w_press) begin
      if (w_class == KC_ESC) begin
        w_opsNext   = '0;
        w_idxNext   = '0;
        w_cntNext   = '0;
        w_doneNext  = 1'b0;
        w_stateNext = ST_ENTRY;
      end else if (r_state == ST_ENTRY) begin
        case (w_class)
          KC_DIGIT: begin
            if (r_cnt != CNT_FULL) begin
              for (int k = 0; k < OPERANDS; k++) begin
                if (IDX_W'(k) == r_op_idx)
                  w_opsNext[k*OPW +: OPW] = (r_operands[k*OPW +: OPW] << 4) | OPW'(w_digit);
              end
              w_cntNext = r_cnt + CNT_W'(1);
            end else begin
              w_ovfPulseNext = 1'b1;
            end
          end
          KC_BKSP: begin
            if (r_cnt != '0) begin
              for (int k = 0; k < OPERANDS; k++) begin
                if (IDX_W'(k) == r_op_idx)
                  w_opsNext[k*OPW +: OPW] = r_operands[k*OPW +: OPW] >> 4;
              end
              w_cntNext = r_cnt - CNT_W'(1);
            end
          end
          KC_ENTER: begin
            if (r_op_idx != IDX_LAST) begin
              w_idxNext = r_op_idx + IDX_W'(1);
              w_cntNext = '0;
            end else begin
              w_stateNext     = ST_DONE;
              w_donePulseNext = 1'b1;
              w_doneNext      = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (w_class == KC_DIGIT) begin
        // A digit after completion starts a fresh entry with that digit already in.
        w_opsNext          = '0;
        w_opsNext[OPW-1:0] = OPW'(w_digit);
        w_idxNext          = '0;
        w_cntNext          = CNT_W'(1);
        w_doneNext         = 1'b0;
        w_stateNext        = ST_ENTRY;
      end
    end
  end

  always_ff @(posedge fcrystal) begin
    if (rst) begin
      r_state     <= ST_ENTRY;
      r_operands  <= '0;
      r_op_idx    <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_donePulse <= 1'b0;
      r_ovfPulse  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_operands  <= w_opsNext;
      r_op_idx    <= w_idxNext;
      r_cnt       <= w_cntNext;
      r_done      <= w_doneNext;
      r_donePulse <= w_donePulseNext;
      r_ovfPulse  <= w_ovfPulseNext;
    end
  end

  assign bus.operands   = r_operands;
  assign bus.op_idx     = r_op_idx;
  assign bus.digit_cnt  = r_cnt;
  assign bus.entry_done = r_done;
  assign bus.done_pulse = r_donePulse;
  assign bus.ovf_pulse  = r_ovfPulse;

endmodule

// File: tb/tb_kbd_bcd_entry.sv
// Scoreboard bench for kbd_bcd_entry: directed key events push hand-computed results,
// per-instance monitors compare them one cycle after each key event.
module tb_kbd_bcd_entry;

  typedef struct {
    logic [31:0] ops;
    int          idx;
    int          cnt;
    bit          done;
    bit          dp;
    bit          ovf;
  } exp_t;

  logic fcrystal;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   monOn    = 0;
  bit   sawA     = 0;
  bit   sawB     = 0;
  exp_t expA[$];
  exp_t expB[$];

  kbd_bcd_entry_if #(.DIGITS(4), .OPERANDS(2)) ifA ();
  kbd_bcd_entry_if #(.DIGITS(1), .OPERANDS(1)) ifB ();

  kbd_bcd_entry #(.DIGITS(4), .OPERANDS(2)) dutA (
    .fcrystal (fcrystal),
    .rst      (rst),
    .bus      (ifA)
  );

  kbd_bcd_entry #(.DIGITS(1), .OPERANDS(1)) dutB (
    .fcrystal (fcrystal),
    .rst      (rst),
    .bus      (ifB)
  );

  initial begin
    fcrystal = 1'b0;
    forever #5 fcrystal = ~fcrystal;
  end

  task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", nm, act, expv);
    end
  endtask

  task automatic checkOutput(input string who, input logic [31:0] aOps, input logic [31:0] aIdx,
                             input logic [31:0] aCnt, input logic aDone, input logic aDp,
                             input logic aOvf, input exp_t e);
    checkField({who, ".operands"},   aOps, e.ops);
    checkField({who, ".op_idx"},     aIdx, 32'(e.idx));
    checkField({who, ".digit_cnt"},  aCnt, 32'(e.cnt));
    checkField({who, ".entry_done"}, 32'(aDone), 32'(e.done));
    checkField({who, ".done_pulse"}, 32'(aDp), 32'(e.dp));
    checkField({who, ".ovf_pulse"},  32'(aOvf), 32'(e.ovf));
  endtask

  // One key event on instance A or B, optionally with reset asserted in the same cycle.
  task automatic applyStimulus(input bit onB, input logic [8:0] code, input bit make, input bit withRst,
                               input logic [31:0] eOps, input int eIdx, input int eCnt,
                               input bit eDone, input bit eDp, input bit eOvf);
    exp_t e;
    e.ops = eOps; e.idx = eIdx; e.cnt = eCnt; e.done = eDone; e.dp = eDp; e.ovf = eOvf;
    if (onB) expB.push_back(e);
    else     expA.push_back(e);
    @(negedge fcrystal);
    rst = withRst;
    if (onB) begin
      ifB.key_valid = 1'b1; ifB.last_change = code; ifB.key_down[code] = make;
    end else begin
      ifA.key_valid = 1'b1; ifA.last_change = code; ifA.key_down[code] = make;
    end
    @(negedge fcrystal);
    ifA.key_valid = 1'b0;
    ifB.key_valid = 1'b0;
    rst = 1'b0;
    @(negedge fcrystal);
  endtask

  always @(posedge fcrystal) begin
    sawA <= ifA.key_valid;
    sawB <= ifB.key_valid;
  end

  always @(negedge fcrystal) begin
    if (sawA) begin
      if (expA.size() == 0) checkField("A.unexpected_event", 32'd1, 32'd0);
      else checkOutput("A", ifA.operands, 32'(ifA.op_idx), 32'(ifA.digit_cnt),
                       ifA.entry_done, ifA.done_pulse, ifA.ovf_pulse, expA.pop_front());
    end else if (monOn) begin
      checkField("A.idle_done_pulse", 32'(ifA.done_pulse), 32'd0);
      checkField("A.idle_ovf_pulse",  32'(ifA.ovf_pulse),  32'd0);
    end
  end

  always @(negedge fcrystal) begin
    if (sawB) begin
      if (expB.size() == 0) checkField("B.unexpected_event", 32'd1, 32'd0);
      else checkOutput("B", 32'(ifB.operands), 32'(ifB.op_idx), 32'(ifB.digit_cnt),
                       ifB.entry_done, ifB.done_pulse, ifB.ovf_pulse, expB.pop_front());
    end else if (monOn) begin
      checkField("B.idle_done_pulse", 32'(ifB.done_pulse), 32'd0);
      checkField("B.idle_ovf_pulse",  32'(ifB.ovf_pulse),  32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ifA.key_valid = 1'b0; ifA.last_change = '0; ifA.key_down = '0;
    ifB.key_valid = 1'b0; ifB.last_change = '0; ifB.key_down = '0;
    repeat (3) @(negedge fcrystal);
    rst = 1'b0;
    monOn = 1;
    $display("[TB] reset state");
    applyStimulus(0, 9'h016, 0, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    $display("[TB] fill operand and overflow");
    applyStimulus(0, 9'h016, 1, 0, 32'h0000_0001, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h01E, 1, 0, 32'h0000_0012, 0, 2, 0, 0, 0);
    applyStimulus(0, 9'h026, 1, 0, 32'h0000_0123, 0, 3, 0, 0, 0);
    applyStimulus(0, 9'h025, 1, 0, 32'h0000_1234, 0, 4, 0, 0, 0);
    applyStimulus(0, 9'h02E, 1, 0, 32'h0000_1234, 0, 4, 0, 0, 1);
    applyStimulus(0, 9'h076, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    $display("[TB] backspace");
    applyStimulus(0, 9'h046, 1, 0, 32'h0000_0009, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h03E, 1, 0, 32'h0000_0098, 0, 2, 0, 0, 0);
    applyStimulus(0, 9'h066, 1, 0, 32'h0000_0009, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h066, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    applyStimulus(0, 9'h066, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    $display("[TB] two operands to completion");
    applyStimulus(0, 9'h016, 1, 0, 32'h0000_0001, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h01E, 1, 0, 32'h0000_0012, 0, 2, 0, 0, 0);
    applyStimulus(0, 9'h05A, 1, 0, 32'h0000_0012, 1, 0, 0, 0, 0);
    applyStimulus(0, 9'h07A, 1, 0, 32'h0003_0012, 1, 1, 0, 0, 0);
    applyStimulus(0, 9'h15A, 1, 0, 32'h0003_0012, 1, 1, 1, 1, 0);
    applyStimulus(0, 9'h05A, 1, 0, 32'h0003_0012, 1, 1, 1, 0, 0);
    applyStimulus(0, 9'h066, 1, 0, 32'h0003_0012, 1, 1, 1, 0, 0);
    $display("[TB] restart from done");
    applyStimulus(0, 9'h03D, 1, 0, 32'h0000_0007, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h03D, 0, 0, 32'h0000_0007, 0, 1, 0, 0, 0);
    $display("[TB] escape and reset mid-entry");
    applyStimulus(0, 9'h073, 1, 0, 32'h0000_0075, 0, 2, 0, 0, 0);
    applyStimulus(0, 9'h016, 1, 0, 32'h0000_0751, 0, 3, 0, 0, 0);
    applyStimulus(0, 9'h05A, 1, 0, 32'h0000_0751, 1, 0, 0, 0, 0);
    applyStimulus(0, 9'h025, 1, 0, 32'h0004_0751, 1, 1, 0, 0, 0);
    applyStimulus(0, 9'h076, 1, 0, 32'h0000_0000, 0, 0, 0, 0, 0);
    applyStimulus(0, 9'h01E, 1, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h026, 1, 0, 32'h0000_0023, 0, 2, 0, 0, 0);
    applyStimulus(0, 9'h046, 1, 1, 32'h0000_0000, 0, 0, 0, 0, 0);
    applyStimulus(0, 9'h036, 1, 0, 32'h0000_0006, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h01C, 1, 0, 32'h0000_0006, 0, 1, 0, 0, 0);
    applyStimulus(0, 9'h170, 1, 0, 32'h0000_0006, 0, 1, 0, 0, 0);
    $display("[TB] single operand, single digit");
    applyStimulus(1, 9'h02E, 1, 0, 32'h0000_0005, 0, 1, 0, 0, 0);
    applyStimulus(1, 9'h036, 1, 0, 32'h0000_0005, 0, 1, 0, 0, 1);
    applyStimulus(1, 9'h05A, 1, 0, 32'h0000_0005, 0, 1, 1, 1, 0);
    applyStimulus(1, 9'h01E, 1, 0, 32'h0000_0002, 0, 1, 0, 0, 0);
    repeat (3) @(negedge fcrystal);
    checkField("A.queue_left", 32'(expA.size()), 32'd0);
    checkField("B.queue_left", 32'(expB.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
